// File: rtl/divide64_seq.sv
// Sequential 64/32 unsigned restoring divider, one quotient bit per cycle.
// Define DIVIDE64_FASTFAIL_EN to finish divide-by-zero/overflow ops without iterating.
module divide64_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [63:0] dividend,
    input  logic [31:0] divisor,
    output logic        busy,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        dz,
    output logic        ovf
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [4:0]  r_cnt;
    logic [31:0] r_div;
    logic [32:0] r_prem;
    logic [31:0] r_qsr;
    logic [31:0] r_hi;
    logic [31:0] r_quot;
    logic [31:0] r_rem;
    logic        r_dz;
    logic        r_ovf;

    logic        w_accept;
    logic        w_step;
    logic        w_last;
    logic        w_fast;
    logic        w_in_dz;
    logic        w_in_ovf;
    logic        w_fail;
    logic [32:0] w_sh;
    logic        w_ge;
    logic [32:0] w_prem_nx;
    logic [31:0] w_qsr_nx;

    assign w_in_dz  = (divisor == 32'd0);
    assign w_in_ovf = !w_in_dz && (dividend[63:32] >= divisor);
    assign w_fail   = r_dz | r_ovf;

`ifdef DIVIDE64_FASTFAIL_EN
    assign w_fast = w_accept & (w_in_dz | w_in_ovf);
`else
    assign w_fast = 1'b0;
`endif

    // One restoring step on {partial remainder, quotient shift register}
    assign w_sh      = {r_prem[31:0], r_qsr[31]};
    assign w_ge      = (w_sh >= {1'b0, r_div});
    assign w_prem_nx = w_ge ? (w_sh - {1'b0, r_div}) : w_sh;
    assign w_qsr_nx  = {r_qsr[30:0], w_ge};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = w_fast ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (r_cnt == 5'd31) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy     = 1'b0;
        done     = 1'b0;
        w_accept = 1'b0;
        w_step   = 1'b0;
        w_last   = 1'b0;
        unique case (r_state)
            S_IDLE: w_accept = start;
            S_RUN: begin
                busy   = 1'b1;
                w_step = 1'b1;
                w_last = (r_cnt == 5'd31);
            end
            S_DONE: done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= 5'd0;
            r_div  <= 32'd0;
            r_prem <= 33'd0;
            r_qsr  <= 32'd0;
            r_hi   <= 32'd0;
            r_quot <= 32'd0;
            r_rem  <= 32'd0;
            r_dz   <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_div  <= divisor;
                r_prem <= {1'b0, dividend[63:32]};
                r_qsr  <= dividend[31:0];
                r_hi   <= dividend[63:32];
                r_cnt  <= 5'd0;
                r_dz   <= w_in_dz;
                r_ovf  <= w_in_ovf;
            end else if (w_step) begin
                r_prem <= w_prem_nx;
                r_qsr  <= w_qsr_nx;
                r_cnt  <= r_cnt + 5'd1;
            end
            // Results only move when an operation completes, so they hold otherwise
            if (w_fast) begin
                r_quot <= 32'hFFFF_FFFF;
                r_rem  <= dividend[63:32];
            end else if (w_last) begin
                r_quot <= w_fail ? 32'hFFFF_FFFF : w_qsr_nx;
                r_rem  <= w_fail ? r_hi : w_prem_nx[31:0];
            end
        end
    end

    assign quotient  = r_quot;
    assign remainder = r_rem;
    assign dz        = r_dz;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_divide64_seq.sv
// Self-checking bench for divide64_seq: vector table plus scoreboarded
// start-while-busy, start-in-DONE and mid-run reset sequences.
module tb_divide64_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [63:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        dz;
    logic        ovf;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [63:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        logic        ovf;
    } vec_t;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        logic        ovf;
        int          lat;
    } exp_t;

`ifdef DIVIDE64_FASTFAIL_EN
    localparam int FAIL_LAT = 0;
`else
    localparam int FAIL_LAT = 32;
`endif

    exp_t sb[$];
    vec_t vecs[$];

    divide64_seq dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .dz        (dz),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic vec_t mk(input logic [63:0] a, input logic [31:0] b,
                                input logic [31:0] q, input logic [31:0] r,
                                input logic d, input logic o);
        vec_t v;
        v.a = a; v.b = b; v.q = q; v.r = r; v.dz = d; v.ovf = o;
        return v;
    endfunction

    function automatic vec_t model(input logic [63:0] a, input logic [31:0] b);
        vec_t v;
        v.a = a; v.b = b; v.dz = 1'b0; v.ovf = 1'b0;
        if (b == 32'd0) begin
            v.dz = 1'b1; v.q = 32'hFFFF_FFFF; v.r = a[63:32];
        end else if (a[63:32] >= b) begin
            v.ovf = 1'b1; v.q = 32'hFFFF_FFFF; v.r = a[63:32];
        end else begin
            v.q = 32'(a / {32'd0, b});
            v.r = 32'(a % {32'd0, b});
        end
        return v;
    endfunction

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            checks++;
            if (busy && done) begin
                failures++;
                $display("FAIL busy_done_overlap actual=busy%0b_done%0b required=not_both",
                         busy, done);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    // Runs one op; inject_k drives a stray start mid-run, pre_arm raises
    // start with nxt during DONE, chained means start is already high.
    task automatic run_op(input vec_t v, input int inject_k, input bit pre_arm,
                          input bit chained, input vec_t nxt);
        exp_t e;
        int k;
        if (!chained) begin
            @(negedge clk);
            start = 1'b1; dividend = v.a; divisor = v.b;
        end
        @(posedge clk);
        e.q = v.q; e.r = v.r; e.dz = v.dz; e.ovf = v.ovf;
        e.lat = (v.dz || v.ovf) ? FAIL_LAT : 32;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        chk("accepted", 64'(busy | done), 64'd1);
        k = 0;
        while (!done && k < 100) begin
            @(negedge clk);
            k++;
            if (k == inject_k) begin
                start = 1'b1; dividend = nxt.a; divisor = nxt.b;
            end else if (k == inject_k + 1) begin
                start = 1'b0;
            end
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL done_timeout actual=no_done required=done");
            sb.delete();
        end else begin
            e = sb.pop_front();
            chk("quotient", 64'(quotient), 64'(e.q));
            chk("remainder", 64'(remainder), 64'(e.r));
            chk("dz", 64'(dz), 64'(e.dz));
            chk("ovf", 64'(ovf), 64'(e.ovf));
            chk("latency", 64'(k), 64'(e.lat));
            if (pre_arm) begin
                start = 1'b1; dividend = nxt.a; divisor = nxt.b;
            end
            @(negedge clk);
            chk("done_one_cycle", 64'(done), 64'd0);
            chk("idle_not_busy", 64'(busy), 64'd0);
            chk("quotient_hold", 64'(quotient), 64'(e.q));
            chk("remainder_hold", 64'(remainder), 64'(e.r));
        end
    endtask

    initial begin
        vec_t v100;
        vec_t v93;
        vec_t none;
        logic [31:0] rb;
        logic [31:0] rhi;

        rst = 1'b1; start = 1'b0; dividend = 64'd0; divisor = 32'd0;
        none = mk(64'd0, 32'd1, 32'd0, 32'd0, 1'b0, 1'b0);

        vecs.push_back(mk(64'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0));
        vecs.push_back(mk(64'hFFFFFFFE_00000001, 32'hFFFFFFFF,
                          32'hFFFFFFFF, 32'd0, 1'b0, 1'b0));
        vecs.push_back(mk(64'h12345678_9ABCDEF0, 32'd0,
                          32'hFFFFFFFF, 32'h12345678, 1'b1, 1'b0));
        vecs.push_back(mk(64'h00000005_00000000, 32'd5,
                          32'hFFFFFFFF, 32'd5, 1'b0, 1'b1));
        vecs.push_back(mk(64'd0, 32'd1, 32'd0, 32'd0, 1'b0, 1'b0));
        vecs.push_back(mk(64'h00000000_FFFFFFFF, 32'd1,
                          32'hFFFFFFFF, 32'd0, 1'b0, 1'b0));
        vecs.push_back(mk(64'h00000001_00000000, 32'd2,
                          32'h80000000, 32'd0, 1'b0, 1'b0));
        vecs.push_back(mk(64'h00000003_00000000, 32'd3,
                          32'hFFFFFFFF, 32'd3, 1'b0, 1'b1));
        vecs.push_back(mk(64'd1000000007, 32'd10,
                          32'd100000000, 32'd7, 1'b0, 1'b0));
        for (int i = 0; i < 8; i++) begin
            rb = $urandom;
            if (rb == 32'd0) rb = 32'd1;
            rhi = $urandom % rb;
            vecs.push_back(model({rhi, 32'($urandom)}, rb));
        end

        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_quotient", 64'(quotient), 64'd0);
        chk("rst_remainder", 64'(remainder), 64'd0);
        chk("rst_dz", 64'(dz), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            run_op(vecs[i], -1, 1'b0, 1'b0, none);
        end

        v100 = mk(64'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0);
        v93  = mk(64'd9, 32'd3, 32'd3, 32'd0, 1'b0, 1'b0);
        run_op(v100, 5, 1'b1, 1'b0, v93);
        run_op(v93, -1, 1'b0, 1'b1, none);

        @(negedge clk);
        start = 1'b1; dividend = v100.a; divisor = v100.b;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_done", 64'(done), 64'd0);
        chk("mid_rst_quotient", 64'(quotient), 64'd0);
        chk("mid_rst_remainder", 64'(remainder), 64'd0);
        chk("mid_rst_dz", 64'(dz), 64'd0);
        chk("mid_rst_ovf", 64'(ovf), 64'd0);
        @(negedge clk);
        chk("rst_hold_done", 64'(done), 64'd0);
        rst = 1'b0;
        run_op(mk(64'd12345, 32'd100, 32'd123, 32'd45, 1'b0, 1'b0),
               -1, 1'b0, 1'b0, none);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
